// File: rtl/local_endpoint.sv
// local_endpoint: packet injector and receiver on the local port of a mesh router.
// TX side frames {len,dest} header + len payload flits toward the router's local input.
// RX side buffers delivered flits in a small FIFO and reframes them for the local client.
module local_endpoint #(
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [7:0]  tx_dest,
  input  logic [7:0]  tx_len,
  output logic        tx_ack,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        router_full,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_full,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  input  logic        out_ready,
  output logic        err_overflow,
  output logic        err_misroute
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [3:0] NX = 4'(NODE_X);
  localparam logic [3:0] NY = 4'(NODE_Y);
  localparam logic [7:0] LOCAL_ADDR = {NX, NY};
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(RX_DEPTH);

  // ---------------------------------------------------------------- TX side
  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_t;

  tx_state_t  state_reg, state_next;
  logic [7:0] dest_reg, len_reg;
  logic [7:0] rem_reg, rem_next;

  // TX state register; dest/len are captured on the accept cycle so the client may change them afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= TX_IDLE;
      rem_reg   <= 8'd0;
      dest_reg  <= 8'd0;
      len_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      if (state_reg == TX_IDLE && tx_req) begin
        dest_reg <= tx_dest;
        len_reg  <= tx_len;
      end
    end
  end

  // TX next-state and handshake outputs; nothing is offered to the router while it reports full
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    tx_ack     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 16'h0000;
    pl_ready   = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        tx_ack = tx_req;
        if (tx_req) state_next = TX_HEAD;
      end
      TX_HEAD: begin
        if (!router_full) begin
          tx_valid = 1'b1;
          tx_data  = {len_reg, dest_reg};
          if (len_reg == 8'd0) begin
            state_next = TX_IDLE;
          end else begin
            state_next = TX_BODY;
            rem_next   = len_reg;
          end
        end
      end
      TX_BODY: begin
        pl_ready = !router_full;
        if (pl_valid && !router_full) begin
          tx_valid = 1'b1;
          tx_data  = pl_data;
          rem_next = rem_reg - 8'd1;
          if (rem_reg == 8'd1) state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX side
  logic [15:0]   mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    fcnt_reg;
  logic          err_overflow_reg, err_misroute_reg;
  logic          do_read, do_write;
  logic [15:0]   head;

  // A full FIFO still accepts a write when the head is popped in the same cycle
  always_comb begin
    rx_full   = (count_reg == DEPTH_CNT);
    out_valid = (count_reg != '0);
    head      = mem[rd_ptr_reg];
    do_read   = out_valid && out_ready;
    do_write  = rx_valid && (!rx_full || do_read);
    out_data  = out_valid ? head : 16'h0000;
    out_sof   = out_valid && (fcnt_reg == 8'd0);
    out_eof   = out_valid && (((fcnt_reg == 8'd0) && (head[15:8] == 8'd0)) || (fcnt_reg == 8'd1));
    err_overflow = err_overflow_reg;
    err_misroute = err_misroute_reg;
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= rx_data;
  end

  // FIFO pointers, occupancy, frame counter and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      fcnt_reg         <= 8'd0;
      err_overflow_reg <= 1'b0;
      err_misroute_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_write, do_read})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (rx_valid && rx_full && !do_read) err_overflow_reg <= 1'b1;
      if (do_read) begin
        if (fcnt_reg == 8'd0) begin
          fcnt_reg <= head[15:8];
          if (head[7:0] != LOCAL_ADDR) err_misroute_reg <= 1'b1;
        end else begin
          fcnt_reg <= fcnt_reg - 8'd1;
        end
      end
    end
  end

endmodule
